uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single AVR serial transmit channel (the tx_data / new_tx_data / tx_busy byte interface of the AVR interface block) between up to 8 byte-stream requesters, for example the message printer and an ADC sample reporter.
- Grants are packet-level and round-robin: once a requester is granted, its bytes go out uninterleaved until it marks a byte last or goes silent past a timeout.
- Sits in the top level between the requester blocks and the AVR interface.

Parameters:
NUM_REQ, 2, number of requesters (legal range 2..8)
IDLE_TIMEOUT, 1000, clk cycles a granted requester may leave req_valid low before its grant is revoked (must be >= 1)
IDX_W, 1, width of grant_idx; must equal clog2(NUM_REQ)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  reset; synchronous, active-high
req_data  input  8*NUM_REQ  packed bytes; requester i drives bits [8i+7:8i]
req_valid  input  NUM_REQ  requester i has a byte on its lane
req_last  input  NUM_REQ  the byte on lane i ends requester i's packet
req_ready  output  NUM_REQ  combinational; lane i byte is consumed this cycle
tx_data  output  8  byte to the AVR interface
new_tx_data  output  1  one-cycle strobe; tx_data is valid
tx_busy  input  1  AVR interface serializer busy
grant_valid  output  1  a requester currently owns the channel
grant_idx  output  IDX_W  index of the current owner
timeout_pulse  output  1  one-cycle strobe when a grant is revoked by timeout

Behaviour:
- Reset values: all registered outputs 0, i.e. tx_data=0, new_tx_data=0, grant_valid=0, grant_idx=0, timeout_pulse=0. req_ready=0 because state=IDLE. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset. Timeout counter=0.
- States: IDLE, ISSUE, SETTLE.
- IDLE:
  - If any req_valid bit is set, choose the first set index scanning (last+1) mod NUM_REQ upward with wrap-around.
  - On the next edge: grant_idx=choice, grant_valid=1, last=choice, counter=0, go to ISSUE.
  - If no req_valid bit is set, stay in IDLE.
- ISSUE (g = grant_idx):
  - Accept condition: req_valid[g] && !tx_busy. While it holds, req_ready[g]=1; req_ready is 0 in every other state and on every other lane.
  - On accept, next edge: tx_data=req_data lane g, new_tx_data=1 for exactly one cycle, counter=0, release flag = req_last[g], go to SETTLE.
  - If req_valid[g]=0: counter increments. When counter reaches IDLE_TIMEOUT-1 with req_valid[g] still 0, next edge: go to IDLE, grant_valid=0, timeout_pulse=1 for one cycle.
  - If req_valid[g]=1 but tx_busy=1: counter holds and the byte waits. A busy channel never triggers a timeout.
- SETTLE:
  - Lasts exactly one cycle. It covers the one-cycle lag before tx_busy rises after a new_tx_data strobe.
  - Next state is IDLE with grant_valid=0 if the release flag is set, else ISSUE.
- Latency: valid requester in IDLE at cycle 0 → grant at cycle 1 → accept (req_ready) at cycle 1 if tx_busy=0 → new_tx_data at cycle 2.
- Byte rate is bounded by the AVR interface; the arbiter adds at most 1 idle cycle between bytes.
- Non-owner lanes are ignored while a grant is held, even if they assert req_valid. No preemption.
- Simultaneous requests are resolved by round-robin from last+1. After a packet releases, the owner has the lowest priority in the next arbitration.
- Single-byte packets (req_last on the first byte) are legal: the grant is released after SETTLE.
- req_last seen with req_valid=0 has no effect.
- rst asserted mid-packet: everything returns to reset values on the next edge and any pending strobe is dropped. A byte already handed to the serializer completes on its own. The round-robin pointer resets.
- req_data and req_last are sampled only in the accept cycle. Requesters must hold data stable while valid and not yet ready.

Test Plan:
- Single requester, 3-byte packet 0x48,0x49,0x0A with last on 0x0A, tx_busy modelled high for 10 cycles after each strobe → three new_tx_data pulses carrying those bytes in order, no overlap with tx_busy, grant_valid drops the cycle after the third SETTLE.
- Requesters 0 and 1 both valid from reset with 2-byte packets → requester 0 is served fully first, then requester 1. With both re-requesting, the next grants alternate 0,1,0.
- Requester 1 granted mid-packet while requester 0 asserts valid → zero req_ready pulses on lane 0 until requester 1 sends its last byte.
- IDLE_TIMEOUT=5, requester 2 sends one non-last byte then drops valid → timeout_pulse exactly 5 cycles after the accept-cycle counter reset, grant_valid=0, then a pending requester 3 is granted.
- tx_busy held high for 50 cycles with requester valid → no req_ready, no timeout, and the byte is sent on the first cycle tx_busy=0.
- rst pulsed the cycle after a strobe during a 4-byte packet → all outputs 0 next cycle, and after release requester 0 gets priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AVR serial transmit byte channel
// between NUM_REQ byte-stream requesters, with an idle timeout on the owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int IDX_W        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout_pulse
);

  localparam int               CNT_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] last_ptr, last_ptr_n, grant_idx_n, choice;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             release_flag, release_flag_n;
  logic             grant_valid_n, new_tx_data_n, timeout_pulse_n, any_req;
  logic [7:0]       tx_data_n, own_data;
  logic             own_valid, own_last;

  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        own_data  = req_data[8*i +: 8];
        own_valid = req_valid[i];
        own_last  = req_last[i];
      end
    end
  end

  // Candidates are visited in order last_ptr+1, last_ptr+2, ... with wrap;
  // both loops are constant-bounded so every lane index is a constant.
  always_comb begin
    int unsigned idx;
    any_req = 1'b0;
    choice  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = 32'(last_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any_req && idx == i && req_valid[i]) begin
          any_req = 1'b1;
          choice  = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_n         = state;
    last_ptr_n      = last_ptr;
    grant_idx_n     = grant_idx;
    grant_valid_n   = grant_valid;
    cnt_n           = cnt;
    release_flag_n  = release_flag;
    tx_data_n       = tx_data;
    new_tx_data_n   = 1'b0;
    timeout_pulse_n = 1'b0;
    req_ready       = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_idx_n   = choice;
          last_ptr_n    = choice;
          grant_valid_n = 1'b1;
          cnt_n         = '0;
          state_n       = ISSUE;
        end
      end
      ISSUE: begin
        if (own_valid && !tx_busy) begin
          req_ready      = NUM_REQ'(1) << grant_idx;
          tx_data_n      = own_data;
          new_tx_data_n  = 1'b1;
          release_flag_n = own_last;
          cnt_n          = '0;
          state_n        = SETTLE;
        end else if (!own_valid) begin
          if (cnt == CNT_LAST) begin
            grant_valid_n   = 1'b0;
            timeout_pulse_n = 1'b1;
            state_n         = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (release_flag) begin
          grant_valid_n = 1'b0;
          state_n       = IDLE;
        end else begin
          state_n = ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_ptr      <= PTR_RST;
      grant_idx     <= '0;
      grant_valid   <= 1'b0;
      cnt           <= '0;
      release_flag  <= 1'b0;
      tx_data       <= '0;
      new_tx_data   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      last_ptr      <= last_ptr_n;
      grant_idx     <= grant_idx_n;
      grant_valid   <= grant_valid_n;
      cnt           <= cnt_n;
      release_flag  <= release_flag_n;
      tx_data       <= tx_data_n;
      new_tx_data   <= new_tx_data_n;
      timeout_pulse <= timeout_pulse_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-lane packet queues, a modelled serializer and a
// transaction-level reference predicting every output each cycle.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int T  = 5;
  localparam int IW = 2;

  typedef struct packed { logic [7:0] d; logic l; } item_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [7:0]      tx_data;
  logic            new_tx_data, tx_busy, grant_valid, timeout_pulse;
  logic [IW-1:0]   grant_idx;

  always #10 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(T), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .timeout_pulse(timeout_pulse)
  );

  item_t lane_q[N][$];
  bit    lane_pause[N];
  bit    force_busy;
  int    ser_len = 10;
  int    ser_cnt = 0;

  // reference: owner (-1 = nobody), rotating pointer, silent-cycle tally
  int            m_owner, m_ptr, m_silent;
  bit            m_settle, m_rel;
  logic [7:0]    e_data;
  logic          e_new, e_gv, e_to;
  logic [IW-1:0] e_gi;

  int checks = 0;
  int errors = 0;
  int grant_log[$];
  bit prev_gv = 1'b0;
  int ready_cnt[N];
  int to_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_silent = 0; m_settle = 1'b0; m_rel = 1'b0;
    e_data = '0; e_new = 1'b0; e_gv = 1'b0; e_to = 1'b0; e_gi = '0;
  endtask

  task automatic push_byte(input int lane, input logic [7:0] d, input logic l);
    lane_q[lane].push_back('{d: d, l: l});
  endtask

  task automatic push_pkt(input int lane, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) push_byte(lane, base + 8'(k), (k == len - 1));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    logic [N-1:0]   v, l, e_ready;
    logic [8*N-1:0] d;
    logic [7:0]     n_data;
    logic           n_new, n_to;
    logic [IW-1:0]  n_gi;
    bit             ser_busy, busy, accept;
    int             pick, c;
    item_t          head;
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0 && !lane_pause[i]) begin
        v[i] = 1'b1; d[8*i +: 8] = lane_q[i][0].d; l[i] = lane_q[i][0].l;
      end else begin
        v[i] = 1'b0; d[8*i +: 8] = 8'($urandom); l[i] = 1'($urandom);
      end
    end
    ser_busy  = (ser_cnt > 0);
    busy      = ser_busy || force_busy;
    req_valid = v; req_data = d; req_last = l; tx_busy = busy;
    @(negedge clk);

    e_ready = '0;
    accept  = 1'b0;
    if (m_owner >= 0 && !m_settle && v[m_owner] && !busy) begin
      e_ready[m_owner] = 1'b1;
      accept = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("new_tx_data", 32'(new_tx_data), 32'(e_new));
    chk("tx_data", 32'(tx_data), 32'(e_data));
    chk("grant_valid", 32'(grant_valid), 32'(e_gv));
    if (e_gv) chk("grant_idx", 32'(grant_idx), 32'(e_gi));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(e_to));
    if (ser_busy) chk("strobe_while_busy", 32'(new_tx_data), 32'd0);

    if (grant_valid === 1'b1 && !prev_gv) grant_log.push_back(int'(grant_idx));
    prev_gv = (grant_valid === 1'b1);
    for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) ready_cnt[i]++;
    if (timeout_pulse === 1'b1) to_cnt++;

    if (e_new) ser_cnt = ser_len;
    else if (ser_cnt > 0) ser_cnt--;

    n_new = 1'b0; n_to = 1'b0; n_data = e_data; n_gi = e_gi;
    head  = '0;
    if (accept) head = lane_q[m_owner].pop_front();
    if (rst) begin
      model_reset();
      n_data = '0; n_gi = '0;
    end else if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (v[c]) begin pick = c; break; end
      end
      if (pick >= 0) begin
        m_owner = pick; m_ptr = pick; m_silent = 0; n_gi = IW'(pick);
      end
    end else if (m_settle) begin
      m_settle = 1'b0;
      if (m_rel) m_owner = -1;
    end else if (accept) begin
      n_new = 1'b1; n_data = head.d; m_rel = head.l; m_settle = 1'b1; m_silent = 0;
    end else if (!v[m_owner]) begin
      m_silent++;
      if (m_silent == T) begin m_owner = -1; n_to = 1'b1; end
    end
    e_new = n_new; e_to = n_to; e_data = n_data; e_gi = n_gi;
    e_gv  = (m_owner >= 0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = all_empty() && (m_owner < 0);
    end
    chk("drain_within_budget", 32'(done), 32'd1);
  endtask

  task automatic wait_strobe(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = e_new;
    end
    chk("strobe_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    int g0, t0, r0, exp_order[4];
    bit ok;
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0; force_busy = 1'b0;
    for (int i = 0; i < N; i++) begin lane_pause[i] = 1'b0; ready_cnt[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    step();

    // single requester, 3-byte packet
    push_byte(0, 8'h48, 1'b0); push_byte(0, 8'h49, 1'b0); push_byte(0, 8'h0A, 1'b1);
    drain(200);

    // two requesters from reset, then alternating re-requests
    rst = 1'b1; step(); rst = 1'b0;
    grant_log.delete();
    push_pkt(0, 2, 8'h10); push_pkt(1, 2, 8'h20); push_pkt(0, 2, 8'h30); push_pkt(1, 2, 8'h40);
    drain(400);
    exp_order = '{0, 1, 0, 1};
    chk("rr_grant_count", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("rr_grant_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));

    // no preemption of an in-progress packet
    push_pkt(1, 3, 8'h50);
    repeat (3) step();
    push_pkt(0, 1, 8'h60);
    r0 = ready_cnt[0];
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin step(); ok = (lane_q[1].size() == 0); end
    chk("lane1_finished", 32'(ok), 32'd1);
    chk("no_preempt_lane0", 32'(ready_cnt[0] - r0), 32'd0);
    drain(200);

    // owner goes silent: timeout, then pending requester 3
    push_byte(2, 8'h70, 1'b0);
    repeat (3) step();
    push_pkt(3, 2, 8'h80);
    t0 = to_cnt; g0 = grant_log.size();
    repeat (30) step();
    chk("timeout_count", 32'(to_cnt - t0), 32'd1);
    chk("grant_after_timeout", (grant_log.size() > g0) ? 32'(grant_log[g0]) : 32'hFFFF_FFFF, 32'd3);
    drain(200);

    // long busy: no accept, no timeout
    force_busy = 1'b1;
    push_pkt(1, 1, 8'h90);
    r0 = ready_cnt[1]; t0 = to_cnt;
    repeat (50) step();
    chk("busy_no_ready", 32'(ready_cnt[1] - r0), 32'd0);
    chk("busy_no_timeout", 32'(to_cnt - t0), 32'd0);
    force_busy = 1'b0;
    drain(100);

    // reset the cycle after a strobe inside a 4-byte packet
    push_pkt(3, 4, 8'hA0);
    wait_strobe(200);
    step();
    rst = 1'b1;
    push_pkt(0, 2, 8'hB0);
    g0 = grant_log.size();
    step();
    rst = 1'b0;
    drain(300);
    chk("grant_after_reset", (grant_log.size() > g0) ? 32'(grant_log[g0]) : 32'hFFFF_FFFF, 32'd0);

    // randomized traffic
    ser_len = 3;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 15) == 0)
        push_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)), 8'($urandom));
      for (int i = 0; i < N; i++) lane_pause[i] = ($urandom_range(0, 7) == 0);
      force_busy = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) ser_len = int'($urandom_range(0, 6));
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; force_busy = 1'b0;
    for (int i = 0; i < N; i++) lane_pause[i] = 1'b0;
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
